zimbo_memarb: RTL and testbench

Two-port arbiter that shares the single-port synchronous 16-bit memory behind the Zimbo core between the CPU memory port and a DMA/loader port. It sits between the core's memory interface and the SRAM, drives the SRAM address, data and strobes, and stalls whichever requester loses. The CPU has priority by default. A starvation counter and a bounded DMA burst guarantee forward progress for both sides.

---
 rtl/zimbo_memarb.sv | 123 ++++++++++++
 tb/tb_zimbo_memarb.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/zimbo_memarb.sv
// zimbo_memarb: shares the single-port 16-bit SRAM between the CPU and DMA ports.
// CPU wins by default; starvation and burst counters bound each side's wait.
module zimbo_memarb #(
    parameter int STARVE_LIM = 8,
    parameter int BURST_LEN  = 4,
    parameter int DW         = 16,
    parameter int AW         = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    output logic          m_we,
    output logic          m_re,
    input  logic [DW-1:0] m_rdata
);

    localparam int WCW = $clog2(STARVE_LIM + 1);
    localparam int BCW = $clog2(BURST_LEN + 1);

    typedef enum logic {
        CPU_PRI = 1'b0,
        DMA_PRI = 1'b1
    } pri_t;

    pri_t           pri;
    logic [WCW-1:0] wait_cnt;
    logic [BCW-1:0] burst_cnt;
    logic           rd_pend;
    logic           rd_owner;
    logic [AW-1:0]  addr_q;
    logic [DW-1:0]  wdata_q;

    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!reset) begin
            if (pri == CPU_PRI) begin
                c_gnt = c_req;
                d_gnt = d_req & ~c_req;
            end else begin
                d_gnt = d_req;
                c_gnt = c_req & ~d_req;
            end
        end
    end

    // Idle cycles keep the last address/data on the SRAM bus.
    always_comb begin
        m_addr  = addr_q;
        m_wdata = wdata_q;
        if (c_gnt) begin
            m_addr  = c_addr;
            m_wdata = c_wdata;
        end else if (d_gnt) begin
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end
    end

    assign m_we = (c_gnt & c_we) | (d_gnt & d_we);
    assign m_re = (c_gnt & ~c_we) | (d_gnt & ~d_we);

    // Gating with reset drops a read return that lands in a reset cycle.
    assign c_rvalid = rd_pend & ~rd_owner & ~reset;
    assign d_rvalid = rd_pend & rd_owner & ~reset;
    assign c_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            pri       <= CPU_PRI;
            wait_cnt  <= '0;
            burst_cnt <= '0;
            rd_pend   <= 1'b0;
            rd_owner  <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            addr_q   <= m_addr;
            wdata_q  <= m_wdata;
            rd_pend  <= m_re;
            rd_owner <= d_gnt;
            unique case (pri)
                CPU_PRI: begin
                    if (wait_cnt == WCW'(STARVE_LIM)) begin
                        pri       <= DMA_PRI;
                        wait_cnt  <= '0;
                        burst_cnt <= '0;
                    end else if (d_req && !d_gnt) begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                DMA_PRI: begin
                    if (!d_req || burst_cnt == BCW'(BURST_LEN - 1)) begin
                        pri       <= CPU_PRI;
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= burst_cnt + BCW'(1);
                    end
                end
                default: pri <= CPU_PRI;
            endcase
        end
    end

endmodule

// File: tb/tb_zimbo_memarb.sv
// tb_zimbo_memarb: directed vector table plus contention/reset sequences,
// with a behavioural SRAM behind the arbiter.
module tb_zimbo_memarb;

    logic        clock;
    logic        reset;
    logic        c_req, c_we, d_req, d_we;
    logic [15:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
    logic [15:0] c_rdata, d_rdata;
    logic [15:0] m_addr, m_wdata, m_rdata;
    logic        m_we, m_re;

    int checks   = 0;
    int failures = 0;

    zimbo_memarb dut (
        .clock(clock), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_re(m_re),
        .m_rdata(m_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [15:0] iv(input logic [15:0] a);
        return {a[7:0], ~a[7:0]};
    endfunction

    bit [15:0] mem [0:1023];
    bit        wr  [0:1023];

    always @(posedge clock) begin
        if (m_we) begin
            mem[m_addr[9:0]] <= m_wdata;
            wr[m_addr[9:0]]  <= 1'b1;
        end
        if (m_re)
            m_rdata <= wr[m_addr[9:0]] ? mem[m_addr[9:0]] : iv(m_addr);
    end

    typedef struct {
        logic        rst, cr, cw;
        logic [15:0] ca, cd;
        logic        dr, dw;
        logic [15:0] da, dd;
        logic        gc, gd, we, re, crv, drv;
        logic [15:0] ma, md, rd;
    } vec_t;

    function automatic vec_t vec(
        input logic rst, cr, cw, input logic [15:0] ca, cd,
        input logic dr, dw, input logic [15:0] da, dd,
        input logic gc, gd, we, re, crv, drv,
        input logic [15:0] ma, md, rd);
        vec_t v;
        v.rst = rst; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.dr = dr; v.dw = dw; v.da = da; v.dd = dd;
        v.gc = gc; v.gd = gd; v.we = we; v.re = re;
        v.crv = crv; v.drv = drv; v.ma = ma; v.md = md; v.rd = rd;
        return v;
    endfunction

    function automatic vec_t idle(input logic crv, drv,
                                  input logic [15:0] rd);
        return vec(0, 0, 0, 0, 0, 0, 0, 0, 0,
                   0, 0, 0, 0, crv, drv, 0, 0, rd);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic apply(input string tag, input vec_t v);
        @(negedge clock);
        reset = v.rst;
        c_req = v.cr; c_we = v.cw; c_addr = v.ca; c_wdata = v.cd;
        d_req = v.dr; d_we = v.dw; d_addr = v.da; d_wdata = v.dd;
        #1;
        chk({tag, " c_gnt"}, 32'(c_gnt), 32'(v.gc));
        chk({tag, " d_gnt"}, 32'(d_gnt), 32'(v.gd));
        chk({tag, " m_we"}, 32'(m_we), 32'(v.we));
        chk({tag, " m_re"}, 32'(m_re), 32'(v.re));
        chk({tag, " c_rvalid"}, 32'(c_rvalid), 32'(v.crv));
        chk({tag, " d_rvalid"}, 32'(d_rvalid), 32'(v.drv));
        if (v.we || v.re)
            chk({tag, " m_addr"}, 32'(m_addr), 32'(v.ma));
        if (v.we)
            chk({tag, " m_wdata"}, 32'(m_wdata), 32'(v.md));
        if (v.crv)
            chk({tag, " c_rdata"}, 32'(c_rdata), 32'(v.rd));
        if (v.drv)
            chk({tag, " d_rdata"}, 32'(d_rdata), 32'(v.rd));
    endtask

    // Both ports read continuously; arbiter starts in CPU_PRI with
    // wait_cnt=0, so grants run 9 CPU then 4 DMA, repeating.
    task automatic run_cont(input string tag, input int n,
                            output logic last_c);
        logic pc, pd, cpu;
        int   w, wmax;
        pc = 0; pd = 0; w = 0; wmax = 0;
        for (int k = 0; k < n; k++) begin
            cpu = (k % 13) < 9;
            apply($sformatf("%s k%0d", tag, k),
                  vec(0, 1, 0, 16'h0030, 0, 1, 0, 16'h0200, 0,
                      cpu, !cpu, 0, 1, pc, pd,
                      cpu ? 16'h0030 : 16'h0200, 0,
                      pc ? iv(16'h0030) : iv(16'h0200)));
            if (d_gnt) w = 0;
            else begin
                w++;
                if (w > wmax) wmax = w;
            end
            pc = cpu; pd = !cpu;
        end
        chk({tag, " dma_wait_le_9"}, 32'(wmax <= 9), 32'd1);
        last_c = pc;
    endtask

    vec_t tbl[$];
    logic lc;

    initial begin
        reset = 1; c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;

        tbl.push_back(vec(1, 1, 0, 0, 0, 1, 0, 16'h0100, 0,
                          0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(vec(1, 1, 0, 0, 0, 1, 0, 16'h0100, 0,
                          0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(vec(0, 1, 1, 16'h0010, 16'h00A5, 1, 0, 16'h0100, 0,
                          1, 0, 1, 0, 0, 0, 16'h0010, 16'h00A5, 0));
        tbl.push_back(vec(0, 1, 0, 16'h0010, 0, 0, 0, 0, 0,
                          1, 0, 0, 1, 0, 0, 16'h0010, 0, 0));
        tbl.push_back(idle(1, 0, 16'h00A5));
        for (int i = 0; i < 8; i++)
            tbl.push_back(vec(0, 0, 0, 0, 0, 1, 0, 16'(16'h0100 + i), 0,
                              0, 1, 0, 1, 0, i > 0, 16'(16'h0100 + i), 0,
                              iv(16'(16'h00FF + i))));
        tbl.push_back(idle(0, 1, iv(16'h0107)));
        tbl.push_back(vec(0, 1, 0, 16'h0020, 0, 1, 0, 16'h0300, 0,
                          1, 0, 0, 1, 0, 0, 16'h0020, 0, 0));
        tbl.push_back(vec(0, 0, 0, 0, 0, 1, 1, 16'h0140, 16'hBEEF,
                          0, 1, 1, 0, 1, 0, 16'h0140, 16'hBEEF, iv(16'h0020)));
        tbl.push_back(vec(0, 0, 0, 0, 0, 1, 0, 16'h0140, 0,
                          0, 1, 0, 1, 0, 0, 16'h0140, 0, 0));
        tbl.push_back(idle(0, 1, 16'hBEEF));
        tbl.push_back(idle(0, 0, 0));

        foreach (tbl[i])
            apply($sformatf("tbl%0d", i), tbl[i]);

        run_cont("cont", 26, lc);
        apply("cont_tail", idle(lc, !lc, lc ? iv(16'h0030) : iv(16'h0200)));

        // Two DMA grants in DMA_PRI, then d_req drops: CPU granted at once.
        run_cont("early", 11, lc);
        apply("early_drop", vec(0, 1, 0, 16'h0030, 0, 0, 0, 0, 0,
                                1, 0, 0, 1, 0, 1, 16'h0030, 0, iv(16'h0200)));
        apply("early_back", vec(0, 1, 0, 16'h0030, 0, 1, 0, 16'h0200, 0,
                                1, 0, 0, 1, 1, 0, 16'h0030, 0, iv(16'h0030)));
        apply("early_tail", idle(1, 0, iv(16'h0030)));

        apply("crst_rd", vec(0, 1, 0, 16'h0010, 0, 0, 0, 0, 0,
                             1, 0, 0, 1, 0, 0, 16'h0010, 0, 0));
        apply("crst_rst", vec(1, 1, 0, 16'h0010, 0, 1, 0, 16'h0200, 0,
                              0, 0, 0, 0, 0, 0, 0, 0, 0));
        apply("crst_post", idle(0, 0, 0));

        // Reset while in DMA_PRI with a DMA read in flight.
        run_cont("drst", 10, lc);
        apply("drst_rst", vec(1, 1, 0, 16'h0030, 0, 1, 0, 16'h0200, 0,
                              0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_cont("drst_after", 14, lc);
        apply("drst_tail", idle(lc, !lc, lc ? iv(16'h0030) : iv(16'h0200)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
